ram_s3board_ctl: RTL and testbench

Synchronous initiator for the two IS61LV25616AL-10T 256Kx16 asynchronous SRAMs on the S3 board. It converts single-word read and write requests from the CPU/memory side into glitch-free SRAM strobe sequences on the shared address, OE and WE lines and the per-chip data, CE, UB and LB lines. It sits between the PDP-8 memory interface and the board SRAM pins, or the SRAM simulation model in the bench.

---
 rtl/ram_s3board_ctl.sv | 212 +++++++++++++++++++++
 tb/tb_ram_s3board_ctl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_s3board_ctl.sv
// ram_s3board_ctl: single-word read/write initiator for the two 256Kx16
// asynchronous SRAMs on the S3 board. Each request becomes one fixed-length
// strobe sequence. Every SRAM-side output is driven directly by a flop.
module ram_s3board_ctl #(
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic        bank,
    input  logic [17:0] addr,
    input  logic [15:0] wdata,
    input  logic [1:0]  be,
    output logic [15:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic [17:0] ram_a,
    output logic        ram_oe_n,
    output logic        ram_we_n,
    inout  wire  [15:0] ram1_io,
    inout  wire  [15:0] ram2_io,
    output logic        ram1_ce_n,
    output logic        ram1_ub_n,
    output logic        ram1_lb_n,
    output logic        ram2_ce_n,
    output logic        ram2_ub_n,
    output logic        ram2_lb_n
);

    localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CW       = $clog2(MAX_WAIT) + 1;
    localparam logic [CW-1:0] RD_LAST = CW'(RD_WAIT - 1);
    localparam logic [CW-1:0] WR_LAST = CW'(WR_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WSETUP,
        S_WPULSE,
        S_WHOLD,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;

    logic            r_bank;
    logic [1:0]      r_be;
    logic [15:0]     r_dout;
    logic [15:0]     r_rdata;
    logic            r_ack;
    logic            r_busy;
    logic [17:0]     r_ram_a;
    logic            r_oe_n;
    logic            r_we_n;
    logic            r_ce1_n, r_ub1_n, r_lb1_n;
    logic            r_ce2_n, r_ub2_n, r_lb2_n;
    logic            r_io1_oe, r_io2_oe;

    logic            w_accept;
    logic            w_capture;
    logic            w_bank;
    logic [1:0]      w_be;
    logic            w_sel_act;
    logic            w_drive;
    logic            w_oe_n_d, w_we_n_d;
    logic            w_ce1_n_d, w_ub1_n_d, w_lb1_n_d;
    logic            w_ce2_n_d, w_ub2_n_d, w_lb2_n_d;
    logic            w_io1_oe_d, w_io2_oe_d;
    logic [15:0]     w_rd_bus;
    logic [15:0]     w_rd_masked;

    // State register and wait counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next state plus the next-cycle value of every strobe. The strobes are
    // decoded from the next state so they can be registered and still line up
    // with the state they belong to; on the accept edge bank/be come straight
    // from the request since the latches are being loaded on that same edge.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_accept     = 1'b1;
                    w_cnt_next   = '0;
                    w_next_state = we ? S_WSETUP : S_RD;
                end
            end
            S_RD: begin
                if (r_cnt == RD_LAST) begin
                    w_capture    = 1'b1;
                    w_next_state = S_DONE;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_WSETUP: begin
                w_cnt_next   = '0;
                w_next_state = S_WPULSE;
            end
            S_WPULSE: begin
                if (r_cnt == WR_LAST) begin
                    w_next_state = S_WHOLD;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_WHOLD: w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase

        w_bank    = w_accept ? bank : r_bank;
        w_be      = w_accept ? be   : r_be;
        w_sel_act = (w_next_state == S_RD)     || (w_next_state == S_WSETUP) ||
                    (w_next_state == S_WPULSE) || (w_next_state == S_WHOLD);
        w_drive   = (w_next_state == S_WSETUP) || (w_next_state == S_WPULSE) ||
                    (w_next_state == S_WHOLD);

        w_oe_n_d   = (w_next_state != S_RD);
        w_we_n_d   = (w_next_state != S_WPULSE);
        w_ce1_n_d  = ~(w_sel_act & ~w_bank);
        w_ub1_n_d  = ~(w_sel_act & ~w_bank & w_be[1]);
        w_lb1_n_d  = ~(w_sel_act & ~w_bank & w_be[0]);
        w_ce2_n_d  = ~(w_sel_act &  w_bank);
        w_ub2_n_d  = ~(w_sel_act &  w_bank & w_be[1]);
        w_lb2_n_d  = ~(w_sel_act &  w_bank & w_be[0]);
        w_io1_oe_d = w_drive & ~w_bank;
        w_io2_oe_d = w_drive &  w_bank;

        w_rd_bus    = r_bank ? ram2_io : ram1_io;
        w_rd_masked = {r_be[1] ? w_rd_bus[15:8] : 8'h00,
                       r_be[0] ? w_rd_bus[7:0]  : 8'h00};
    end

    // Request latches, read-data capture and registered SRAM-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bank   <= 1'b0;
            r_be     <= '0;
            r_dout   <= '0;
            r_rdata  <= '0;
            r_ack    <= 1'b0;
            r_busy   <= 1'b0;
            r_ram_a  <= '0;
            r_oe_n   <= 1'b1;
            r_we_n   <= 1'b1;
            r_ce1_n  <= 1'b1;
            r_ub1_n  <= 1'b1;
            r_lb1_n  <= 1'b1;
            r_ce2_n  <= 1'b1;
            r_ub2_n  <= 1'b1;
            r_lb2_n  <= 1'b1;
            r_io1_oe <= 1'b0;
            r_io2_oe <= 1'b0;
        end else begin
            if (w_accept) begin
                r_bank  <= bank;
                r_be    <= be;
                r_dout  <= wdata;
                r_ram_a <= addr;
            end
            if (w_capture) begin
                r_rdata <= w_rd_masked;
            end
            r_ack    <= (w_next_state == S_DONE);
            r_busy   <= (w_next_state != S_IDLE);
            r_oe_n   <= w_oe_n_d;
            r_we_n   <= w_we_n_d;
            r_ce1_n  <= w_ce1_n_d;
            r_ub1_n  <= w_ub1_n_d;
            r_lb1_n  <= w_lb1_n_d;
            r_ce2_n  <= w_ce2_n_d;
            r_ub2_n  <= w_ub2_n_d;
            r_lb2_n  <= w_lb2_n_d;
            r_io1_oe <= w_io1_oe_d;
            r_io2_oe <= w_io2_oe_d;
        end
    end

    assign rdata     = r_rdata;
    assign ack       = r_ack;
    assign busy      = r_busy;
    assign ram_a     = r_ram_a;
    assign ram_oe_n  = r_oe_n;
    assign ram_we_n  = r_we_n;
    assign ram1_ce_n = r_ce1_n;
    assign ram1_ub_n = r_ub1_n;
    assign ram1_lb_n = r_lb1_n;
    assign ram2_ce_n = r_ce2_n;
    assign ram2_ub_n = r_ub2_n;
    assign ram2_lb_n = r_lb2_n;
    assign ram1_io   = r_io1_oe ? r_dout : 'z;
    assign ram2_io   = r_io2_oe ? r_dout : 'z;

endmodule

// File: tb/tb_ram_s3board_ctl.sv
// Bench for ram_s3board_ctl: two instances (fast and slow wait settings),
// each attached to a pair of behavioural SRAMs sharing one backing array.
module tb_ram_s3board_ctl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        req_a = 1'b0, req_b = 1'b0;
    logic        we = 1'b0, bank = 1'b0;
    logic [17:0] addr = '0;
    logic [15:0] wdata = '0;
    logic [1:0]  be = '0;

    logic [15:0] a_rdata, b_rdata;
    logic        a_ack, a_busy, b_ack, b_busy;
    logic [17:0] a_ram_a, b_ram_a;
    logic        a_oe_n, a_we_n, a_ce1_n, a_ub1_n, a_lb1_n, a_ce2_n, a_ub2_n, a_lb2_n;
    logic        b_oe_n, b_we_n, b_ce1_n, b_ub1_n, b_lb1_n, b_ce2_n, b_ub2_n, b_lb2_n;
    wire  [15:0] a_io1, a_io2, b_io1, b_io2;

    ram_s3board_ctl #(.RD_WAIT(1), .WR_WAIT(1)) dut_a (
        .clk(clk), .reset(reset), .req(req_a), .we(we), .bank(bank), .addr(addr),
        .wdata(wdata), .be(be), .rdata(a_rdata), .ack(a_ack), .busy(a_busy),
        .ram_a(a_ram_a), .ram_oe_n(a_oe_n), .ram_we_n(a_we_n),
        .ram1_io(a_io1), .ram2_io(a_io2),
        .ram1_ce_n(a_ce1_n), .ram1_ub_n(a_ub1_n), .ram1_lb_n(a_lb1_n),
        .ram2_ce_n(a_ce2_n), .ram2_ub_n(a_ub2_n), .ram2_lb_n(a_lb2_n)
    );

    ram_s3board_ctl #(.RD_WAIT(3), .WR_WAIT(2)) dut_b (
        .clk(clk), .reset(reset), .req(req_b), .we(we), .bank(bank), .addr(addr),
        .wdata(wdata), .be(be), .rdata(b_rdata), .ack(b_ack), .busy(b_busy),
        .ram_a(b_ram_a), .ram_oe_n(b_oe_n), .ram_we_n(b_we_n),
        .ram1_io(b_io1), .ram2_io(b_io2),
        .ram1_ce_n(b_ce1_n), .ram1_ub_n(b_ub1_n), .ram1_lb_n(b_lb1_n),
        .ram2_ce_n(b_ce2_n), .ram2_ub_n(b_ub2_n), .ram2_lb_n(b_lb2_n)
    );

    // SRAM models: index 0/1 = dut_a ram1/ram2, 2/3 = dut_b ram1/ram2.
    // Output is driven on OE plus either byte lane, independent of CE.
    logic [15:0] mem [4][262144];
    int          wr_cnt [4];
    logic        bd_en = 1'b0;
    int          bd_idx = 0;
    logic [17:0] bd_addr = '0;
    logic [15:0] bd_data = '0;

    assign a_io1 = (!a_oe_n && !(a_ub1_n && a_lb1_n)) ? mem[0][a_ram_a] : 16'hzzzz;
    assign a_io2 = (!a_oe_n && !(a_ub2_n && a_lb2_n)) ? mem[1][a_ram_a] : 16'hzzzz;
    assign b_io1 = (!b_oe_n && !(b_ub1_n && b_lb1_n)) ? mem[2][b_ram_a] : 16'hzzzz;
    assign b_io2 = (!b_oe_n && !(b_ub2_n && b_lb2_n)) ? mem[3][b_ram_a] : 16'hzzzz;

    // SRAM write model (mid-cycle while WE and CE are low) plus backdoor preload.
    always @(negedge clk) begin
        if (bd_en) mem[bd_idx][bd_addr] <= bd_data;
        if (!a_we_n && !a_ce1_n) begin
            if (!a_ub1_n) mem[0][a_ram_a][15:8] <= a_io1[15:8];
            if (!a_lb1_n) mem[0][a_ram_a][7:0]  <= a_io1[7:0];
            if (!(a_ub1_n && a_lb1_n)) wr_cnt[0] <= wr_cnt[0] + 1;
        end
        if (!a_we_n && !a_ce2_n) begin
            if (!a_ub2_n) mem[1][a_ram_a][15:8] <= a_io2[15:8];
            if (!a_lb2_n) mem[1][a_ram_a][7:0]  <= a_io2[7:0];
            if (!(a_ub2_n && a_lb2_n)) wr_cnt[1] <= wr_cnt[1] + 1;
        end
        if (!b_we_n && !b_ce1_n) begin
            if (!b_ub1_n) mem[2][b_ram_a][15:8] <= b_io1[15:8];
            if (!b_lb1_n) mem[2][b_ram_a][7:0]  <= b_io1[7:0];
            if (!(b_ub1_n && b_lb1_n)) wr_cnt[2] <= wr_cnt[2] + 1;
        end
        if (!b_we_n && !b_ce2_n) begin
            if (!b_ub2_n) mem[3][b_ram_a][15:8] <= b_io2[15:8];
            if (!b_lb2_n) mem[3][b_ram_a][7:0]  <= b_io2[7:0];
            if (!(b_ub2_n && b_lb2_n)) wr_cnt[3] <= wr_cnt[3] + 1;
        end
    end

    typedef struct {
        bit          is_rd;
        logic [15:0] exp;
        int          c0;
        int          lat;
    } sb_t;

    typedef struct {
        bit          w;
        bit          bk;
        logic [17:0] ad;
        logic [15:0] wd;
        logic [1:0]  b;
        logic [15:0] exp;
    } vec_t;

    sb_t sb_q0[$];
    sb_t sb_q1[$];
    int  n_pass = 0, n_total = 0;
    int  cyc = 0;
    int  ack_cnt [2];
    int  we_run [2], we_last [2], oe_run [2], oe_last [2];
    int  overlap = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic void mon(int d, logic ack_s, logic oe_n_s, logic we_n_s,
                                logic drv_s, logic [15:0] rd_s);
        sb_t e;
        if (!oe_n_s && drv_s) overlap++;
        if (!we_n_s) we_run[d]++;
        else if (we_run[d] != 0) begin we_last[d] = we_run[d]; we_run[d] = 0; end
        if (!oe_n_s) oe_run[d]++;
        else if (oe_run[d] != 0) begin oe_last[d] = oe_run[d]; oe_run[d] = 0; end
        if (ack_s) begin
            ack_cnt[d]++;
            if ((d == 0) ? (sb_q0.size() == 0) : (sb_q1.size() == 0)) begin
                n_total++;
                $display("FAIL unexpected_ack dut%0d: got ack=1 expected ack=0 (cycle %0d)", d, cyc);
            end else begin
                e = (d == 0) ? sb_q0.pop_front() : sb_q1.pop_front();
                if (e.is_rd) chk($sformatf("rdata_dut%0d", d), 32'(rd_s), 32'(e.exp));
                chk($sformatf("ack_latency_dut%0d", d), cyc - e.c0 + 1, e.lat);
            end
        end
    endfunction

    // One clock: sample #1 after the rising edge, then run the monitors.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        mon(0, a_ack, a_oe_n, a_we_n, dut_a.r_io1_oe | dut_a.r_io2_oe, a_rdata);
        mon(1, b_ack, b_oe_n, b_we_n, dut_b.r_io1_oe | dut_b.r_io2_oe, b_rdata);
    endtask

    task automatic backdoor(input int idx, input logic [17:0] ad, input logic [15:0] dat);
        bd_idx = idx; bd_addr = ad; bd_data = dat; bd_en = 1'b1;
        @(negedge clk);
        #1;
        bd_en = 1'b0;
    endtask

    task automatic issue(input int d, input bit w, input bit bk, input logic [17:0] ad,
                         input logic [15:0] wd, input logic [1:0] b, input bit track,
                         input logic [15:0] exp, input int lat);
        sb_t e;
        we = w; bank = bk; addr = ad; wdata = wd; be = b;
        if (d == 0) req_a = 1'b1; else req_b = 1'b1;
        step();
        req_a = 1'b0; req_b = 1'b0;
        if (track) begin
            e.is_rd = !w; e.exp = exp; e.c0 = cyc; e.lat = lat;
            if (d == 0) sb_q0.push_back(e); else sb_q1.push_back(e);
        end
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        while (((d == 0) ? (sb_q0.size() != 0 || a_busy) : (sb_q1.size() != 0 || b_busy)) && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) begin
            n_total++;
            $display("FAIL timeout_dut%0d: got busy/pending after 50 cycles expected idle", d);
            if (d == 0) sb_q0.delete(); else sb_q1.delete();
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: got no finish expected finish within 200us");
        $fatal(1);
    end

    vec_t vt [12];
    int   acks0, wr0, wr_all;

    initial begin
        vt[0]  = '{1'b0, 1'b1, 18'o777777, 16'h0000, 2'b11, 16'hA534};
        vt[1]  = '{1'b0, 1'b0, 18'o777777, 16'h0000, 2'b11, 16'hBEEF};
        vt[2]  = '{1'b0, 1'b1, 18'o777777, 16'h0000, 2'b01, 16'h0034};
        vt[3]  = '{1'b0, 1'b1, 18'o777777, 16'h0000, 2'b10, 16'hA500};
        vt[4]  = '{1'b1, 1'b0, 18'o0,      16'h5A5A, 2'b00, 16'h0000};
        vt[5]  = '{1'b0, 1'b0, 18'o0,      16'h0000, 2'b11, 16'hC3C3};
        vt[6]  = '{1'b1, 1'b0, 18'o0,      16'h1357, 2'b01, 16'h0000};
        vt[7]  = '{1'b0, 1'b0, 18'o0,      16'h0000, 2'b11, 16'hC357};
        vt[8]  = '{1'b1, 1'b0, 18'h2AAAA,  16'hFFFF, 2'b11, 16'h0000};
        vt[9]  = '{1'b0, 1'b0, 18'h2AAAA,  16'h0000, 2'b11, 16'hFFFF};
        vt[10] = '{1'b0, 1'b0, 18'h2AAAA,  16'h0000, 2'b00, 16'h0000};
        vt[11] = '{1'b0, 1'b1, 18'o0,      16'h0000, 2'b11, 16'h0F0F};

        // Reset held 3 cycles with a write request pending on both instances.
        reset = 1'b1; req_a = 1'b1; req_b = 1'b1;
        we = 1'b1; bank = 1'b0; addr = 18'o1; wdata = 16'hFFFF; be = 2'b11;
        repeat (3) step();
        chk("reset_strobes_a", {a_oe_n, a_we_n, a_ce1_n, a_ub1_n, a_lb1_n, a_ce2_n, a_ub2_n, a_lb2_n}, 8'hFF);
        chk("reset_strobes_b", {b_oe_n, b_we_n, b_ce1_n, b_ub1_n, b_lb1_n, b_ce2_n, b_ub2_n, b_lb2_n}, 8'hFF);
        chk("reset_ack_busy", {a_ack, a_busy, b_ack, b_busy}, 4'b0000);
        chk("reset_rdata_addr", {a_rdata, a_ram_a}, 34'h0);
        chk("reset_io_drive", {dut_a.r_io1_oe, dut_a.r_io2_oe, dut_b.r_io1_oe, dut_b.r_io2_oe}, 4'b0000);
        reset = 1'b0; req_a = 1'b0; req_b = 1'b0;
        step();
        chk("reset_no_write", wr_cnt[0] + wr_cnt[1] + wr_cnt[2] + wr_cnt[3], 0);

        backdoor(0, 18'o1234,   16'o7402);
        backdoor(1, 18'o777777, 16'h1234);
        backdoor(0, 18'o777777, 16'hBEEF);
        backdoor(0, 18'o0,      16'hC3C3);
        backdoor(1, 18'o0,      16'h0F0F);
        backdoor(3, 18'o5,      16'h8421);

        // Read strobe sequence, RD_WAIT=1.
        issue(0, 1'b0, 1'b0, 18'o1234, 16'h0, 2'b11, 1'b1, 16'o7402, 2);
        chk("rd_c1_ce1_oe", {a_ce1_n, a_oe_n, a_ub1_n, a_lb1_n}, 4'b0000);
        chk("rd_c1_ram2_idle", {a_ce2_n, a_ub2_n, a_lb2_n, a_we_n}, 4'b1111);
        chk("rd_c1_addr_busy", {a_ram_a, a_busy, a_ack}, {18'o1234, 2'b10});
        step();
        chk("rd_c2_strobes", {a_ce1_n, a_oe_n, a_ack}, 3'b111);
        step();
        chk("rd_c3_idle", {a_ack, a_busy}, 2'b00);

        // Byte write to ram2, high lane only.
        wr0 = wr_cnt[0];
        issue(0, 1'b1, 1'b1, 18'o777777, 16'hA55A, 2'b10, 1'b1, 16'h0, 4);
        chk("wr_c1_setup", {a_we_n, a_ce2_n, a_ub2_n, a_lb2_n, a_ce1_n, dut_a.r_io2_oe}, 6'b100111);
        step();
        chk("wr_c2_pulse", {a_we_n, a_ce2_n, dut_a.r_io2_oe}, 3'b001);
        step();
        chk("wr_c3_hold", {a_we_n, a_ce2_n, a_ub2_n, dut_a.r_io2_oe}, 4'b1001);
        step();
        chk("wr_c4_done", {a_we_n, a_ce2_n, a_ub2_n, a_lb2_n, dut_a.r_io2_oe}, 5'b11110);
        wait_idle(0);
        chk("wr_ram1_untouched", wr_cnt[0] - wr0, 0);

        // Table of reads and writes on the fast instance.
        for (int i = 0; i < 12; i++) begin
            issue(0, vt[i].w, vt[i].bk, vt[i].ad, vt[i].wd, vt[i].b, 1'b1, vt[i].exp, vt[i].w ? 4 : 2);
            wait_idle(0);
        end

        // Second req during cycle 1 of a read is dropped.
        acks0 = ack_cnt[0];
        issue(0, 1'b0, 1'b0, 18'o1234, 16'h0, 2'b11, 1'b1, 16'o7402, 2);
        req_a = 1'b1; we = 1'b1; addr = 18'o55; wdata = 16'hFFFF;
        step();
        req_a = 1'b0;
        repeat (4) step();
        chk("busy_single_ack", ack_cnt[0] - acks0, 1);
        chk("busy_ignored_idle", a_busy, 1'b0);

        // A req in the first IDLE cycle after DONE is accepted.
        issue(0, 1'b0, 1'b1, 18'o777777, 16'h0, 2'b11, 1'b1, 16'hA534, 2);
        step();
        step();
        chk("b2b_first_idle", {a_ack, a_busy}, 2'b00);
        issue(0, 1'b0, 1'b0, 18'o1234, 16'h0, 2'b11, 1'b1, 16'o7402, 2);
        chk("b2b_accepted", a_busy, 1'b1);
        wait_idle(0);

        // Reset asserted while WE is low.
        issue(0, 1'b1, 1'b0, 18'o55, 16'h1111, 2'b11, 1'b0, 16'h0, 0);
        step();
        chk("rst_mid_in_pulse", a_we_n, 1'b0);
        reset = 1'b1;
        acks0 = ack_cnt[0];
        step();
        reset = 1'b0;
        chk("rst_mid_strobes", {a_we_n, a_oe_n, a_ce1_n, a_ub1_n, a_lb1_n}, 5'b11111);
        chk("rst_mid_io_busy", {dut_a.r_io1_oe, a_busy, a_ack}, 3'b000);
        repeat (4) step();
        chk("rst_mid_no_ack", ack_cnt[0] - acks0, 0);
        issue(0, 1'b0, 1'b0, 18'o1234, 16'h0, 2'b11, 1'b1, 16'o7402, 2);
        wait_idle(0);

        // Slow instance: RD_WAIT=3, WR_WAIT=2.
        issue(1, 1'b0, 1'b1, 18'o5, 16'h0, 2'b11, 1'b1, 16'h8421, 4);
        wait_idle(1);
        chk("slow_oe_cycles", oe_last[1], 3);
        issue(1, 1'b1, 1'b0, 18'o100, 16'h600D, 2'b11, 1'b1, 16'h0, 5);
        wait_idle(1);
        chk("slow_we_cycles", we_last[1], 2);
        issue(1, 1'b0, 1'b0, 18'o100, 16'h0, 2'b11, 1'b1, 16'h600D, 4);
        wait_idle(1);

        chk("oe_io_overlap", overlap, 0);
        wr_all = wr_cnt[2];
        chk("slow_write_seen", (wr_all != 0), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
